// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Optional build macro used by this block: BCD_SIGNED_EN (two's complement input).
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_t;

    localparam int          BCD_DIGIT_W = 4;
    localparam logic [3:0]  ADJ_THRESH  = 4'd5;
    localparam logic [3:0]  ADJ_ADD     = 4'd3;

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Valid/ready bus between a producer/consumer and bin_to_bcd_seq.
// With BCD_SIGNED_EN defined the bus also carries out_sign.
interface bin_to_bcd_seq_if
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
);
    logic [BIN_W-1:0]              in_data;
    logic                          in_valid;
    logic                          in_ready;
    logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd;
    logic                          out_overflow;
    logic                          out_valid;
    logic                          out_ready;
`ifdef BCD_SIGNED_EN
    logic                          out_sign;
`endif

    // Driver/consumer side of the converter.
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_bcd, out_overflow, out_valid
`ifdef BCD_SIGNED_EN
        , input out_sign
`endif
    );

    // Converter side.
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_bcd, out_overflow, out_valid
`ifdef BCD_SIGNED_EN
        , output out_sign
`endif
    );

endinterface

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] din,
    output logic [BCD_DIGIT_W-1:0] dout
);

    // Conditional add-3 applied before every shift.
    always_comb begin
        dout = din;
        if (din >= ADJ_THRESH) begin
            dout = din + ADJ_ADD;
        end else begin
            dout = din;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one operand bit per clock).
// Result appears BIN_W cycles after the operand is accepted; a sticky flag marks
// operands that do not fit in DIGITS decimal digits (out_bcd is then value mod 10^DIGITS).
// Optional macro BCD_SIGNED_EN: operand is two's complement, magnitude is converted
// and the sign is reported on out_sign. Latency is the same in both builds.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
)(
    input  logic           clk,
    input  logic           rst,
    bin_to_bcd_seq_if.slave bus
);

    localparam int ACC_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    bcd_state_t        state_r;
    logic [ACC_W-1:0]  acc_r;
    logic [ACC_W-1:0]  acc_adj_s;
    logic [BIN_W-1:0]  opnd_r;
    logic [BIN_W-1:0]  opnd_s;
    logic [CNT_W-1:0]  cnt_r;
    logic              ovf_r;
    logic              in_ready_r;
    logic              out_valid_r;
`ifdef BCD_SIGNED_EN
    logic              sign_r;
`endif

`ifdef BCD_SIGNED_EN
    // Magnitude of the two's complement operand; the most negative value wraps
    // to itself, which read unsigned is exactly its magnitude.
    always_comb begin
        opnd_s = bus.in_data;
        if (bus.in_data[BIN_W-1]) begin
            opnd_s = ~bus.in_data + BIN_W'(1);
        end else begin
            opnd_s = bus.in_data;
        end
    end
`else
    assign opnd_s = bus.in_data;
`endif

    // One add-3 corrector per BCD digit of the accumulator.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (acc_r[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .dout (acc_adj_s[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Control FSM plus datapath: accept, shift BIN_W times, hold result until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            acc_r       <= '0;
            opnd_r      <= '0;
            cnt_r       <= '0;
            ovf_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
`ifdef BCD_SIGNED_EN
            sign_r      <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid && in_ready_r) begin
                        opnd_r     <= opnd_s;
                        acc_r      <= '0;
                        ovf_r      <= 1'b0;
                        cnt_r      <= CNT_W'(BIN_W);
                        in_ready_r <= 1'b0;
                        state_r    <= SHIFT;
`ifdef BCD_SIGNED_EN
                        sign_r     <= bus.in_data[BIN_W-1];
`endif
                    end
                end
                SHIFT: begin
                    // Corrected accumulator and operand shift left as one register;
                    // whatever leaves the top digit means the value needs more digits.
                    acc_r  <= {acc_adj_s[ACC_W-2:0], opnd_r[BIN_W-1]};
                    opnd_r <= {opnd_r[BIN_W-2:0], 1'b0};
                    ovf_r  <= ovf_r | acc_adj_s[ACC_W-1];
                    cnt_r  <= cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready     = in_ready_r;
    assign bus.out_valid    = out_valid_r;
    assign bus.out_bcd      = acc_r;
    assign bus.out_overflow = ovf_r;
`ifdef BCD_SIGNED_EN
    assign bus.out_sign     = sign_r;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: BIN_W=8 with DIGITS=3 and DIGITS=2 instances.
// Honours BCD_SIGNED_EN for the signed build.
module tb_bin_to_bcd_seq;

    typedef struct packed {
        logic [11:0] bcd;
        logic        ovf;
        logic        sgn;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bin_to_bcd_seq_if #(.BIN_W(8), .DIGITS(3)) bus3 ();
    bin_to_bcd_seq_if #(.BIN_W(8), .DIGITS(2)) bus2 ();

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));
    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    exp_t q3[$];
    exp_t q2[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [11:0] b, input logic o, input logic s);
        exp_t e;
        e.bcd = b;
        e.ovf = o;
        e.sgn = s;
        return e;
    endfunction

    // Reference decimal conversion by integer arithmetic.
    function automatic exp_t model(input logic [7:0] d, input int digits);
        exp_t e;
        int v;
        int lim;
        e.sgn = 1'b0;
        v = int'(d);
`ifdef BCD_SIGNED_EN
        if (d[7]) begin
            e.sgn = 1'b1;
            v = 256 - int'(d);
        end
`endif
        lim   = (digits == 2) ? 100 : 1000;
        e.ovf = (v >= lim);
        v     = v % lim;
        e.bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
        return e;
    endfunction

    // Monitor for the 3-digit converter: compare each handed-over result.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && bus3.out_valid === 1'b1 && bus3.out_ready === 1'b1) begin
            if (q3.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected3 actual=%0h required=none", bus3.out_bcd);
            end else begin
                e = q3.pop_front();
                check("bcd3", 32'(bus3.out_bcd), 32'(e.bcd));
                check("ovf3", 32'(bus3.out_overflow), 32'(e.ovf));
`ifdef BCD_SIGNED_EN
                check("sign3", 32'(bus3.out_sign), 32'(e.sgn));
`endif
            end
        end
    end

    // Monitor for the 2-digit converter.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && bus2.out_valid === 1'b1 && bus2.out_ready === 1'b1) begin
            if (q2.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected2 actual=%0h required=none", bus2.out_bcd);
            end else begin
                e = q2.pop_front();
                check("bcd2", 32'(bus2.out_bcd), 32'(e.bcd[7:0]));
                check("ovf2", 32'(bus2.out_overflow), 32'(e.ovf));
`ifdef BCD_SIGNED_EN
                check("sign2", 32'(bus2.out_sign), 32'(e.sgn));
`endif
            end
        end
    end

    // Offer one operand, wait (bounded) for in_ready, return just after the accept edge.
    task automatic send(input bit sel2, input logic [7:0] d, input exp_t e);
        int n = 0;
        if (sel2) begin
            q2.push_back(e);
            bus2.in_data  = d;
            bus2.in_valid = 1'b1;
            while (bus2.in_ready !== 1'b1 && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
        end else begin
            q3.push_back(e);
            bus3.in_data  = d;
            bus3.in_valid = 1'b1;
            while (bus3.in_ready !== 1'b1 && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL accept_timeout actual=%0d required=<200", n);
        end
        @(posedge clk); #1;
        bus2.in_valid = 1'b0;
        bus3.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q3.size() != 0 || q2.size() != 0) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 500) begin
            total++;
            bad++;
            $display("FAIL drain_timeout actual=%0d required=0", q3.size() + q2.size());
        end
    endtask

    initial begin
        int n;
        int errs;
        rst = 1'b1;
        bus3.in_data = 8'd0; bus3.in_valid = 1'b0; bus3.out_ready = 1'b1;
        bus2.in_data = 8'd0; bus2.in_valid = 1'b0; bus2.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(bus3.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus3.out_valid), 32'd0);
        check("rst_out_bcd",   32'(bus3.out_bcd), 32'd0);
        check("rst_overflow",  32'(bus3.out_overflow), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 255: latency and in_ready low during conversion
`ifdef BCD_SIGNED_EN
        send(1'b0, 8'd255, mk(12'h001, 1'b0, 1'b1));
`else
        send(1'b0, 8'd255, mk(12'h255, 1'b0, 1'b0));
`endif
        n = 0;
        errs = 0;
        while (bus3.out_valid !== 1'b1 && n < 50) begin
            if (bus3.in_ready !== 1'b0) errs++;
            @(posedge clk); #1;
            n++;
        end
        check("latency255", 32'(n), 32'd8);
        check("ready_low255", 32'(errs), 32'd0);
        drain();

        // hand-computed boundary values
        send(1'b0, 8'd0,   mk(12'h000, 1'b0, 1'b0));
        send(1'b0, 8'd99,  mk(12'h099, 1'b0, 1'b0));
        send(1'b0, 8'd100, mk(12'h100, 1'b0, 1'b0));
        drain();

        // back-to-back sweep against the integer reference
        for (int i = 0; i < 256; i++) begin
            send(1'b0, 8'(i), model(8'(i), 3));
        end
        drain();

        // consumer stall: result held, no new acceptance
        bus3.out_ready = 1'b0;
        send(1'b0, 8'd42, mk(12'h042, 1'b0, 1'b0));
        n = 0;
        while (bus3.out_valid !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency42", 32'(n), 32'd8);
        errs = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (bus3.out_valid !== 1'b1 || bus3.out_bcd !== 12'h042 || bus3.in_ready !== 1'b0) errs++;
        end
        check("hold42", 32'(errs), 32'd0);
        bus3.out_ready = 1'b1;
        drain();

        // two-digit instance: overflow and largest fitting value
`ifdef BCD_SIGNED_EN
        send(1'b1, 8'd200, mk(12'h056, 1'b0, 1'b1));
`else
        send(1'b1, 8'd200, mk(12'h000, 1'b1, 1'b0));
`endif
        send(1'b1, 8'd99,  mk(12'h099, 1'b0, 1'b0));
        send(1'b1, 8'd100, model(8'd100, 2));
        send(1'b1, 8'd255, model(8'd255, 2));
        drain();

        // reset in the middle of converting 123
        bus3.in_data  = 8'd123;
        bus3.in_valid = 1'b1;
        n = 0;
        while (bus3.in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        bus3.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_in_ready",  32'(bus3.in_ready), 32'd1);
        check("midrst_out_valid", 32'(bus3.out_valid), 32'd0);
        check("midrst_out_bcd",   32'(bus3.out_bcd), 32'd0);
        check("midrst_overflow",  32'(bus3.out_overflow), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        send(1'b0, 8'd7, mk(12'h007, 1'b0, 1'b0));
        drain();

`ifdef BCD_SIGNED_EN
        // signed extremes
        send(1'b0, 8'h80, mk(12'h128, 1'b0, 1'b1));
        send(1'b0, 8'hFF, mk(12'h001, 1'b0, 1'b1));
        send(1'b0, 8'h7F, mk(12'h127, 1'b0, 1'b0));
        drain();
`endif

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
